// File: rtl/oled_spi_tx.sv
// SSD1351 write-only serial transmitter.
// Converts a byte-wide valid/ready stream into SPI mode-0 frames (MSB first)
// on the OLED panel pins, and generates the panel reset pulse on request.
module oled_spi_tx #(
  parameter int CLK_DIV    = 1,
  parameter int CS_CYCLES  = 1,
  parameter int RES_CYCLES = 40
) (
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic [7:0] TxData,
  input  logic       TxDnC,
  input  logic       TxValid,
  output logic       TxReady,
  input  logic       ResetReq,
  output logic       Busy,
  output logic       nRES,
  output logic       SCLK,
  output logic       SDIN,
  output logic       DnC,
  output logic       nCS
);

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAX_P = max_of(max_of(CLK_DIV, CS_CYCLES), RES_CYCLES);
  localparam int CW    = $clog2(MAX_P) + 1;

  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CS_LAST  = CW'(CS_CYCLES - 1);
  localparam logic [CW-1:0] RES_LAST = CW'(RES_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    RES_LOW  = 3'd0,
    IDLE     = 3'd1,
    CS_SETUP = 3'd2,
    PH_LOW   = 3'd3,
    PH_HIGH  = 3'd4,
    CS_HOLD  = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          nres_q, nres_d;
  logic          sclk_q, sclk_d;
  logic          sdin_q, sdin_d;
  logic          dnc_q, dnc_d;
  logic          ncs_q, ncs_d;
  logic          busy_q, busy_d;
  logic          tx_ready;
  logic          accept;

  // Ready in IDLE, or in the last high phase of bit 0 when a follow-on byte is offered.
  always_comb begin
    tx_ready = 1'b0;
    case (state_q)
      IDLE:    tx_ready = !ResetReq;
      PH_HIGH: tx_ready = (cnt_q == DIV_LAST) && (bit_q == 3'd0) && TxValid && !ResetReq;
      default: tx_ready = 1'b0;
    endcase
  end

  assign accept  = TxValid && tx_ready;
  assign TxReady = tx_ready;

  // Next-state and registered-output computation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    nres_d  = nres_q;
    sclk_d  = sclk_q;
    sdin_d  = sdin_q;
    dnc_d   = dnc_q;
    ncs_d   = ncs_q;
    case (state_q)
      RES_LOW: begin
        nres_d = 1'b0;
        ncs_d  = 1'b1;
        sclk_d = 1'b0;
        if (cnt_q == RES_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          nres_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      IDLE: begin
        sclk_d = 1'b0;
        ncs_d  = 1'b1;
        if (ResetReq) begin
          // A pending reset request wins over an offered byte.
          state_d = RES_LOW;
          cnt_d   = '0;
          nres_d  = 1'b0;
        end else if (accept) begin
          state_d = CS_SETUP;
          cnt_d   = '0;
          ncs_d   = 1'b0;
          dnc_d   = TxDnC;
          sdin_d  = TxData[7];
          sh_d    = TxData;
          bit_d   = 3'd7;
        end
      end
      CS_SETUP: begin
        if (cnt_q == CS_LAST) begin
          state_d = PH_LOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PH_LOW: begin
        if (cnt_q == DIV_LAST) begin
          state_d = PH_HIGH;
          cnt_d   = '0;
          sclk_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PH_HIGH: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d  = '0;
          sclk_d = 1'b0;
          if (bit_q != 3'd0) begin
            // Next bit goes out together with the falling edge.
            bit_d   = bit_q - 3'd1;
            sh_d    = {sh_q[6:0], 1'b0};
            sdin_d  = sh_q[6];
            state_d = PH_LOW;
          end else if (accept) begin
            // Back-to-back byte: keep nCS low and skip the setup phase.
            sh_d    = TxData;
            sdin_d  = TxData[7];
            dnc_d   = TxDnC;
            bit_d   = 3'd7;
            state_d = PH_LOW;
          end else begin
            state_d = CS_HOLD;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      CS_HOLD: begin
        sclk_d = 1'b0;
        if (cnt_q == CS_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          ncs_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = RES_LOW;
        cnt_d   = '0;
        nres_d  = 1'b0;
        ncs_d   = 1'b1;
        sclk_d  = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // Control state and pin registers; reset aborts any transfer immediately.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q <= RES_LOW;
      cnt_q   <= '0;
      nres_q  <= 1'b0;
      sclk_q  <= 1'b0;
      sdin_q  <= 1'b0;
      dnc_q   <= 1'b0;
      ncs_q   <= 1'b1;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      nres_q  <= nres_d;
      sclk_q  <= sclk_d;
      sdin_q  <= sdin_d;
      dnc_q   <= dnc_d;
      ncs_q   <= ncs_d;
      busy_q  <= busy_d;
    end
  end

  // Shift data and bit index; only meaningful while a byte is in flight.
  always_ff @(posedge HCLK) begin
    sh_q  <= sh_d;
    bit_q <= bit_d;
  end

  assign Busy = busy_q;
  assign nRES = nres_q;
  assign SCLK = sclk_q;
  assign SDIN = sdin_q;
  assign DnC  = dnc_q;
  assign nCS  = ncs_q;

endmodule

// File: tb/tb_oled_spi_tx.sv
// Scoreboard testbench for oled_spi_tx: stimulus pushes expected bytes,
// a pin monitor reassembles frames on SCLK rises and checks them.
module tb_oled_spi_tx;

  localparam int CLK_DIV    = 2;
  localparam int CS_CYCLES  = 1;
  localparam int RES_CYCLES = 40;

  logic       HCLK = 1'b0;
  logic       HRESETn = 1'b0;
  logic [7:0] TxData = 8'h00;
  logic       TxDnC = 1'b0;
  logic       TxValid = 1'b0;
  logic       TxReady;
  logic       ResetReq = 1'b0;
  logic       Busy;
  logic       nRES;
  logic       SCLK;
  logic       SDIN;
  logic       DnC;
  logic       nCS;

  oled_spi_tx #(
    .CLK_DIV   (CLK_DIV),
    .CS_CYCLES (CS_CYCLES),
    .RES_CYCLES(RES_CYCLES)
  ) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .TxData  (TxData),
    .TxDnC   (TxDnC),
    .TxValid (TxValid),
    .TxReady (TxReady),
    .ResetReq(ResetReq),
    .Busy    (Busy),
    .nRES    (nRES),
    .SCLK    (SCLK),
    .SDIN    (SDIN),
    .DnC     (DnC),
    .nCS     (nCS)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [7:0] data;
    logic       dnc;
    logic       abort;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Pin monitor
  int         cyc = 0;
  int         bits = 0;
  int         since = 0;
  int         last_rise = 0;
  int         stray = 0;
  int         rises_total = 0;
  bit         have_rise = 1'b0;
  logic [7:0] acc = 8'h00;
  logic       prev_sclk = 1'b0;
  logic       prev_ncs = 1'b1;
  logic       prev_sdin = 1'b0;
  logic       prev_dnc = 1'b0;
  exp_t       mon_e;

  always @(negedge HCLK) begin
    cyc++;
    if (SDIN !== prev_sdin || DnC !== prev_dnc) since = 0;
    else since++;
    if (!prev_ncs && nCS) begin
      if (bits != 0) begin
        if (q.size() == 0) chk("abort_pop", q.size(), 1);
        else begin
          mon_e = q.pop_front();
          chk("abort_flag", mon_e.abort, 1);
        end
        bits = 0;
      end else if (have_rise) begin
        chk("cs_hold", cyc - last_rise, CLK_DIV + CS_CYCLES);
      end
      have_rise = 1'b0;
    end
    if (SCLK && !prev_sclk) begin
      if (nCS) stray++;
      else begin
        rises_total++;
        chk("sdin_setup", since >= CLK_DIV, 1);
        if (have_rise) chk("sclk_period", cyc - last_rise, 2 * CLK_DIV);
        have_rise = 1'b1;
        last_rise = cyc;
        if (q.size() == 0) chk("unexpected_bit", q.size(), 1);
        else begin
          chk("dnc_at_rise", DnC, q[0].dnc);
          acc = {acc[6:0], SDIN};
          bits++;
          if (bits == 8) begin
            mon_e = q.pop_front();
            chk("byte_data", acc, mon_e.data);
            chk("byte_not_abort", mon_e.abort, 0);
            bits = 0;
          end
        end
      end
    end
    prev_sclk = SCLK;
    prev_ncs  = nCS;
    prev_sdin = SDIN;
    prev_dnc  = DnC;
  end

  // Stimulus helpers
  logic hs_sclk;
  int   hs_rises;

  task automatic tick();
    @(negedge HCLK);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic c, input bit hold, input bit ab);
    int   n;
    exp_t e;
    e.data  = d;
    e.dnc   = c;
    e.abort = ab;
    q.push_back(e);
    TxData  = d;
    TxDnC   = c;
    TxValid = 1'b1;
    n = 0;
    while (!TxReady && n < 500) begin
      tick();
      n++;
    end
    chk("handshake", TxReady, 1);
    if (!TxReady) begin
      TxValid = 1'b0;
      return;
    end
    hs_sclk  = SCLK;
    hs_rises = rises_total;
    tick();
    if (!hold) begin
      TxValid = 1'b0;
      TxData  = 8'h00;
      TxDnC   = ~c;
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (Busy && n < 3000) begin
      tick();
      n++;
    end
    chk(name, Busy, 0);
  endtask

  task automatic res_low(output int n, output int bad);
    n = 0;
    bad = 0;
    while (nRES === 1'b0 && n < 500) begin
      n++;
      if (nCS !== 1'b1 || SCLK !== 1'b0) bad++;
      tick();
    end
  endtask

  initial begin
    int   n;
    int   bad;
    int   base;
    exp_t e;

    repeat (3) tick();
    chk("reset_outputs", {nRES, SCLK, SDIN, DnC, nCS, TxReady, Busy}, 7'b0000101);

    // Power-up reset pulse
    HRESETn = 1'b1;
    res_low(n, bad);
    chk("res_low_len", n, RES_CYCLES);
    chk("res_low_pins", bad, 0);
    chk("idle_busy", Busy, 0);
    chk("idle_ready", TxReady, 1);

    // Single command byte 0xA5
    send(8'hA5, 1'b0, 1'b0, 1'b0);
    chk("a5_ncs_fall", nCS, 0);
    chk("a5_first_bit", SDIN, 1);
    chk("a5_dnc", DnC, 0);
    n = 1;
    while (!SCLK && n < 50) begin
      tick();
      n++;
    end
    chk("a5_first_rise", n, 1 + CS_CYCLES + CLK_DIV);
    wait_idle("a5_idle");
    chk("a5_done", q.size(), 0);

    // Back-to-back 0x15 (command) then 0xFF (data)
    base = rises_total;
    send(8'h15, 1'b0, 1'b1, 1'b0);
    send(8'hFF, 1'b1, 1'b0, 1'b0);
    chk("b2b_ready_sclk", hs_sclk, 1);
    chk("b2b_ready_edge", hs_rises - base, 8);
    chk("b2b_dnc_switch", DnC, 1);
    chk("b2b_ncs", nCS, 0);
    chk("b2b_sclk_fall", SCLK, 0);
    wait_idle("b2b_idle");
    chk("b2b_rises", rises_total - base, 16);

    // ResetReq and TxValid together in IDLE
    e.data  = 8'h3C;
    e.dnc   = 1'b1;
    e.abort = 1'b0;
    q.push_back(e);
    ResetReq = 1'b1;
    TxData   = 8'h3C;
    TxDnC    = 1'b1;
    TxValid  = 1'b1;
    #1;
    chk("rr_ready_low", TxReady, 0);
    tick();
    ResetReq = 1'b0;
    res_low(n, bad);
    chk("rr_res_len", n, RES_CYCLES);
    chk("rr_res_pins", bad, 0);
    chk("rr_ready_first_idle", TxReady, 1);
    tick();
    chk("rr_accept", nCS, 0);
    TxValid = 1'b0;
    TxData  = 8'h00;
    wait_idle("rr_idle");

    // Hard reset on the 3rd SCLK rise of a byte
    base = rises_total;
    send(8'h5A, 1'b1, 1'b0, 1'b1);
    n = 0;
    while (rises_total - base < 3 && n < 100) begin
      tick();
      n++;
    end
    chk("abort_reach3", rises_total - base, 3);
    HRESETn = 1'b0;
    tick();
    chk("abort_pins", {nCS, SCLK, nRES}, 3'b100);
    HRESETn = 1'b1;
    wait_idle("abort_idle");
    chk("abort_no_edges", rises_total - base, 3);

    // Input data changes right after acceptance of 0xC3
    send(8'hC3, 1'b0, 1'b0, 1'b0);
    wait_idle("c3_idle");
    chk("c3_done", q.size(), 0);

    chk("stray_sclk", stray, 0);
    chk("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end

endmodule
